// File: rtl/obuff_read_arbiter.sv
// Shares the single obuff read port between the write-back path and the host readout path.
// Latency: grant is combinational in the request cycle; read data/rvalid returns one cycle later.
// Backpressure: requesters hold req/addr until granted; pause_work blocks grants; write-back bursts are capped.
module obuff_read_arbiter #(
  parameter int DATA_WIDTH       = 32,
  parameter int OBUFF_CELL_COUNT = 4096,
  parameter int MAX_WB_BURST     = 8,
  parameter int OBUFF_ADDR_WIDTH = $clog2(OBUFF_CELL_COUNT)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        pause_work,
  input  logic [OBUFF_ADDR_WIDTH:0]   obuff_w_level,
  input  logic                        wb_req,
  input  logic [OBUFF_ADDR_WIDTH-1:0] wb_addr,
  output logic                        wb_grant,
  output logic                        wb_rvalid,
  output logic [DATA_WIDTH-1:0]       wb_rdata,
  input  logic                        host_req,
  input  logic [OBUFF_ADDR_WIDTH-1:0] host_addr,
  output logic                        host_grant,
  output logic                        host_rvalid,
  output logic [DATA_WIDTH-1:0]       host_rdata,
  output logic                        host_rerr,
  output logic                        obuff_r_en,
  output logic [OBUFF_ADDR_WIDTH-1:0] obuff_r_addr,
  input  logic [DATA_WIDTH-1:0]       obuff_r_data,
  output logic [1:0]                  owner
);

  localparam logic [1:0] OWN_IDLE = 2'b00;
  localparam logic [1:0] OWN_WB   = 2'b01;
  localparam logic [1:0] OWN_HOST = 2'b10;

  localparam logic [1:0] TAG_NONE = 2'b00;
  localparam logic [1:0] TAG_WB   = 2'b01;
  localparam logic [1:0] TAG_HOK  = 2'b10;
  localparam logic [1:0] TAG_HERR = 2'b11;

  localparam logic [7:0] BURST_MAX = 8'(MAX_WB_BURST);

  logic [7:0]                  r_run_cnt;
  logic [1:0]                  r_owner;
  logic [1:0]                  r_tag;
  logic [OBUFF_ADDR_WIDTH-1:0] r_last_addr;

  logic w_active;
  logic w_wb_first;
  logic w_host_ok;

  // Arbitration: write-back wins unless the host is waiting and the burst cap is reached.
  always_comb begin
    w_active   = rst && !pause_work;
    w_wb_first = !host_req || (r_run_cnt < BURST_MAX);
    wb_grant   = w_active && wb_req && w_wb_first;
    host_grant = w_active && host_req && !(wb_req && w_wb_first);
    w_host_ok  = {1'b0, host_addr} < obuff_w_level;
  end

  // Read port drive: host reads past the fill level never touch the RAM; address holds when idle.
  always_comb begin
    obuff_r_en   = 1'b0;
    obuff_r_addr = r_last_addr;
    if (wb_grant) begin
      obuff_r_en   = 1'b1;
      obuff_r_addr = wb_addr;
    end else if (host_grant && w_host_ok) begin
      obuff_r_en   = 1'b1;
      obuff_r_addr = host_addr;
    end
  end

  // Burst counter: counts contended write-back grants, cleared once the host is served or absent.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_run_cnt <= 8'd0;
    end else if (!pause_work) begin
      if (host_grant || !host_req) begin
        r_run_cnt <= 8'd0;
      end else if (wb_grant && (r_run_cnt < BURST_MAX)) begin
        r_run_cnt <= r_run_cnt + 8'd1;
      end
    end
  end

  // Owner state: last grant owner, frozen while paused.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_owner <= OWN_IDLE;
    end else if (!pause_work) begin
      if (wb_grant) begin
        r_owner <= OWN_WB;
      end else if (host_grant) begin
        r_owner <= OWN_HOST;
      end else begin
        r_owner <= OWN_IDLE;
      end
    end
  end

  // Response tag and held address: tag advances every cycle so a pre-pause grant still completes.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_tag       <= TAG_NONE;
      r_last_addr <= '0;
    end else begin
      if (wb_grant) begin
        r_tag <= TAG_WB;
      end else if (host_grant) begin
        r_tag <= w_host_ok ? TAG_HOK : TAG_HERR;
      end else begin
        r_tag <= TAG_NONE;
      end
      if (obuff_r_en) begin
        r_last_addr <= obuff_r_addr;
      end
    end
  end

  // Response routing: gated by reset so an in-flight response is dropped as reset asserts.
  always_comb begin
    wb_rvalid   = rst && (r_tag == TAG_WB);
    host_rvalid = rst && r_tag[1];
    host_rerr   = rst && (r_tag == TAG_HERR);
    wb_rdata    = wb_rvalid ? obuff_r_data : '0;
    host_rdata  = (rst && (r_tag == TAG_HOK)) ? obuff_r_data : '0;
    owner       = r_owner;
  end

endmodule

// File: tb/tb_obuff_read_arbiter.sv
module tb_obuff_read_arbiter;

  localparam int AW  = 12;
  localparam int MAX = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          pause_work;
  logic [AW:0]   obuff_w_level;
  logic          wb_req;
  logic [AW-1:0] wb_addr;
  logic          wb_grant;
  logic          wb_rvalid;
  logic [31:0]   wb_rdata;
  logic          host_req;
  logic [AW-1:0] host_addr;
  logic          host_grant;
  logic          host_rvalid;
  logic [31:0]   host_rdata;
  logic          host_rerr;
  logic          obuff_r_en;
  logic [AW-1:0] obuff_r_addr;
  logic [31:0]   obuff_r_data = 32'd0;
  logic [1:0]    owner;

  obuff_read_arbiter #(
    .DATA_WIDTH(32), .OBUFF_CELL_COUNT(4096), .MAX_WB_BURST(MAX)
  ) dut (
    .clk(clk), .rst(rst), .pause_work(pause_work), .obuff_w_level(obuff_w_level),
    .wb_req(wb_req), .wb_addr(wb_addr), .wb_grant(wb_grant), .wb_rvalid(wb_rvalid),
    .wb_rdata(wb_rdata), .host_req(host_req), .host_addr(host_addr),
    .host_grant(host_grant), .host_rvalid(host_rvalid), .host_rdata(host_rdata),
    .host_rerr(host_rerr), .obuff_r_en(obuff_r_en), .obuff_r_addr(obuff_r_addr),
    .obuff_r_data(obuff_r_data), .owner(owner)
  );

  always #5 clk = ~clk;

  // RAM stand-in: word at address a holds a*3, returned one cycle after the read enable
  always @(posedge clk) begin
    if (obuff_r_en) obuff_r_data <= 32'(obuff_r_addr) * 32'd3;
  end

  int n_err = 0;
  int n_chk = 0;

  // Reference model state
  int m_owner = 0;
  int m_burst = 0;
  int m_resp  = 0;     // 0 none, 1 wb, 2 host ok, 3 host err
  int m_raddr = 0;
  int m_last  = 0;
  bit m_known = 1'b0;
  int last_g  = 0;
  int host_grants = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic cyc(input logic rn, input logic pw, input logic wr, input int wa,
                     input logic hr, input int ha, input int lvl);
    int g;
    bit hok;
    bit ren;
    rst = rn; pause_work = pw; wb_req = wr; wb_addr = AW'(wa);
    host_req = hr; host_addr = AW'(ha); obuff_w_level = (AW+1)'(lvl);
    g = 0;
    if (rn && !pw) begin
      if (wr && hr)  g = (m_burst < MAX) ? 1 : 2;
      else if (wr)   g = 1;
      else if (hr)   g = 2;
    end
    hok = (ha < lvl);
    ren = (g == 1) || (g == 2 && hok);
    @(negedge clk);
    chk("wb_grant",   32'(wb_grant),   32'(g == 1));
    chk("host_grant", 32'(host_grant), 32'(g == 2));
    chk("r_en",       32'(obuff_r_en), 32'(ren));
    if (ren)                       chk("r_addr", 32'(obuff_r_addr), 32'((g == 1) ? wa : ha));
    else if (m_known && g == 0)    chk("r_addr_hold", 32'(obuff_r_addr), 32'(m_last));
    if (m_known)                   chk("owner", 32'(owner), 32'(m_owner));
    chk("wb_rvalid",   32'(wb_rvalid),   32'(rn && m_resp == 1));
    chk("host_rvalid", 32'(host_rvalid), 32'(rn && m_resp >= 2));
    chk("host_rerr",   32'(host_rerr),   32'(rn && m_resp == 3));
    chk("wb_rdata",    wb_rdata,   (rn && m_resp == 1) ? 32'(m_raddr * 3) : 32'd0);
    chk("host_rdata",  host_rdata, (rn && m_resp == 2) ? 32'(m_raddr * 3) : 32'd0);
    @(posedge clk);
    if (!rn) begin
      m_owner = 0; m_burst = 0; m_resp = 0; m_last = 0; m_known = 1'b1;
    end else begin
      m_resp  = (g == 0) ? 0 : (g == 1) ? 1 : (hok ? 2 : 3);
      m_raddr = (g == 1) ? wa : ha;
      if (ren) m_last = m_raddr;
      if (!pw) begin
        m_owner = g;
        if (g == 2 || !hr)             m_burst = 0;
        else if (g == 1 && m_burst < MAX) m_burst++;
      end
    end
    if (g == 2) host_grants++;
    last_g = g;
    #1;
  endtask

  initial begin
    bit wr_q, hr_q;
    int wa_q, ha_q, lvl_q, r;
    // Reset with both requesters active, then the first grant must go to write-back
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b1, 1, 1'b1, 2, 4096);
    cyc(1'b1, 1'b0, 1'b1, 1, 1'b1, 2, 4096);
    cyc(1'b1, 1'b0, 1'b0, 0, 1'b0, 0, 4096);
    // Solo write-back reads 5,6,7 back-to-back: data 15,18,21
    for (int a = 5; a <= 7; a++) cyc(1'b1, 1'b0, 1'b1, a, 1'b0, 0, 4096);
    cyc(1'b1, 1'b0, 1'b0, 0, 1'b0, 0, 4096);
    // Contention for 18 cycles: wb x8, host, wb x8, host
    host_grants = 0;
    for (int i = 0; i < 18; i++) begin
      cyc(1'b1, 1'b0, 1'b1, 40 + i, 1'b1, 300, 4096);
      if (i == 8 || i == 17) chk("contend_host_slot", 32'(last_g), 32'd2);
    end
    chk("contend_host_count", 32'(host_grants), 32'd2);
    cyc(1'b1, 1'b0, 1'b0, 0, 1'b0, 0, 4096);
    // Fill-level boundary: 99 succeeds, 100 errors
    cyc(1'b1, 1'b0, 1'b0, 0, 1'b1, 99, 100);
    cyc(1'b1, 1'b0, 1'b0, 0, 1'b1, 100, 100);
    cyc(1'b1, 1'b0, 1'b0, 0, 1'b0, 0, 100);
    // Empty buffer: every host read errors
    cyc(1'b1, 1'b0, 1'b0, 0, 1'b1, 0, 0);
    cyc(1'b1, 1'b0, 1'b0, 0, 1'b0, 0, 0);
    // Pause after a write-back grant: response still lands, grants and state frozen
    cyc(1'b1, 1'b0, 1'b1, 20, 1'b1, 30, 4096);
    for (int i = 0; i < 4; i++) cyc(1'b1, 1'b1, 1'b1, 21, 1'b1, 30, 4096);
    cyc(1'b1, 1'b0, 1'b1, 21, 1'b1, 30, 4096);
    chk("pause_resume_grant", 32'(last_g), 32'd1);
    cyc(1'b1, 1'b0, 1'b0, 0, 1'b0, 0, 4096);
    // Reset while a host read is in flight: response must be dropped
    cyc(1'b1, 1'b0, 1'b0, 0, 1'b1, 10, 100);
    cyc(1'b0, 1'b0, 1'b0, 0, 1'b0, 0, 100);
    cyc(1'b1, 1'b0, 1'b0, 0, 1'b0, 0, 100);
    cyc(1'b1, 1'b0, 1'b0, 0, 1'b0, 0, 100);
    // Randomized traffic with pauses, level changes, early drops and occasional resets
    wr_q = 1'b0; hr_q = 1'b0; wa_q = 0; ha_q = 0; lvl_q = 2048;
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 4) == 0) lvl_q = $urandom_range(0, 4096);
      if (!wr_q || last_g == 1 || $urandom_range(0, 15) == 0) begin
        wr_q = ($urandom_range(0, 2) != 0);
        wa_q = $urandom_range(0, 4095);
      end
      if (!hr_q || last_g == 2 || $urandom_range(0, 15) == 0) begin
        hr_q = ($urandom_range(0, 2) != 0);
        r = $urandom_range(0, 3);
        if (r == 0 && lvl_q > 0)         ha_q = lvl_q - 1;
        else if (r == 1 && lvl_q < 4096) ha_q = lvl_q;
        else                             ha_q = $urandom_range(0, 4095);
      end
      cyc($urandom_range(0, 99) != 0, $urandom_range(0, 9) == 0,
          wr_q, wa_q, hr_q, ha_q, lvl_q);
    end
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/obuff_read_arbiter.md
# obuff_read_arbiter

Shares the wavelet core's single output-buffer (obuff) read port between two requesters: the core's write-back path, which copies approximation coefficients back into the input buffer between decomposition levels, and the host readout path, which drains results through the register decoder. It decides one grant per cycle, drives the obuff read enable and address, and routes the one-cycle-late read data back to the requester that owns it. A bounded-burst rule stops back-to-back write-back traffic from starving the host. It sits between the core controller/decoder and the obuff RAM.

## Interface
- DATA_WIDTH, 32, obuff word width
- OBUFF_CELL_COUNT, 4096, obuff depth in words
- MAX_WB_BURST, 8, maximum number of consecutive contended write-back grants before the host is forced in; legal range 1..255
- OBUFF_ADDR_WIDTH, $clog2(OBUFF_CELL_COUNT), address width
- clk  input  1  the only clock; all logic is on its rising edge
- rst  input  1  reset, synchronous, active-low
- pause_work  input  1  global stall; blocks new grants while high
- obuff_w_level  input  OBUFF_ADDR_WIDTH+1  number of valid words currently held in obuff
- wb_req  input  1  write-back read request
- wb_addr  input  OBUFF_ADDR_WIDTH  write-back read address
- wb_grant  output  1  write-back request accepted this cycle (combinational)
- wb_rvalid  output  1  wb_rdata is valid
- wb_rdata  output  DATA_WIDTH  write-back read data
- host_req  input  1  host read request
- host_addr  input  OBUFF_ADDR_WIDTH  host read address
- host_grant  output  1  host request accepted this cycle (combinational)
- host_rvalid  output  1  host_rdata and host_rerr are valid
- host_rdata  output  DATA_WIDTH  host read data
- host_rerr  output  1  host read targeted an address at or beyond obuff_w_level
- obuff_r_en  output  1  obuff read enable
- obuff_r_addr  output  OBUFF_ADDR_WIDTH  obuff read address
- obuff_r_data  input  DATA_WIDTH  obuff read data, valid one cycle after obuff_r_en
- owner  output  2  last grant owner: 00 IDLE, 01 WB, 10 HOST (for debug and status)

## Operation
- **Owner state machine** (register `owner`):
  - A cycle with a wb grant moves it to WB.
  - A cycle with a host grant moves it to HOST.
  - A cycle with no grant and `pause_work` low moves it to IDLE.
  - While `pause_work` is high, `owner` holds its value.
- **Arbitration.** Grants are evaluated only when `pause_work` is 0; at most one grant is issued per cycle.
  - Only `wb_req` high: grant wb.
  - Only `host_req` high: grant host.
  - Both high: grant wb while `run_cnt < MAX_WB_BURST`; grant host when `run_cnt == MAX_WB_BURST`.
- **Burst counter `run_cnt`** (8 bits, internal):
  - Increments on a wb grant while `host_req` is high.
  - Clears on any host grant, and on any unpaused cycle with `host_req` low.
  - Holds while `pause_work` is high.
  - Saturates at `MAX_WB_BURST`.
- **Memory access on a wb grant:** `obuff_r_en` = 1 and `obuff_r_addr` = `wb_addr` in the same cycle.
- **Memory access on a host grant:**
  - If `host_addr < obuff_w_level` (compare zero-extended to OBUFF_ADDR_WIDTH+1 bits): `obuff_r_en` = 1 and `obuff_r_addr` = `host_addr`.
  - Otherwise: `obuff_r_en` stays 0, and the response is an error.
- **With no grant:** `obuff_r_en` = 0 and `obuff_r_addr` holds its previous value.
- **Response tag.** A registered 2-bit tag records each grant: 00 none, 01 wb, 10 host-ok, 11 host-err. The tag advances every cycle, including paused cycles. A request granted in the cycle before a pause therefore still completes.
- **Response routing** (one cycle after the grant):
  - Tag 01: `wb_rvalid` = 1, `wb_rdata` = `obuff_r_data`.
  - Tag 10: `host_rvalid` = 1, `host_rdata` = `obuff_r_data`, `host_rerr` = 0.
  - Tag 11: `host_rvalid` = 1, `host_rdata` = 0, `host_rerr` = 1.
  - When the corresponding rvalid is 0, the matching rdata output is 0.

## Timing
- **Reset (`rst` = 0 at a rising edge):**
  - `owner` = IDLE, `run_cnt` = 0, tag = none, `obuff_r_addr` = 0.
  - `wb_grant`, `host_grant` and `obuff_r_en` are forced to 0 during reset.
  - `wb_rvalid`, `host_rvalid`, `host_rerr`, `wb_rdata` and `host_rdata` are 0.
  - A response in flight when reset is asserted is dropped; no rvalid appears in the first cycle after reset is released.
- **Latency:** a grant in cycle T produces rvalid in cycle T+1. Sustained throughput is one read per cycle across both requesters.
- **Handshake:**
  - A requester holds req and addr until it sees its grant.
  - It may present a new request in the cycle after the grant.
  - Dropping req before the grant is legal and leaves no side effects.
- **Simultaneous events:**
  - `pause_work` rising in the same cycle as a request: no grant that cycle.
  - Grant and response in the same cycle (back-to-back reads) overlap correctly: the tag pipeline is a single stage.
  - `obuff_w_level` is sampled in the grant cycle only.
- **Boundary addresses:**
  - `host_addr == obuff_w_level - 1`: read succeeds.
  - `host_addr == obuff_w_level`: error.
  - `obuff_w_level == 0`: every host read errors.
- **Starvation bound:** with `wb_req` and `host_req` both held continuously, the host receives exactly one grant in every MAX_WB_BURST+1 unpaused cycles.

## Test plan
- **Reset:** hold `rst` = 0 for 3 cycles with both reqs high -> both grants 0, `obuff_r_en` 0, `owner` 00, all rvalids 0; after release, first grant goes to wb.
- **Solo wb reads:** wb reads addresses 5, 6, 7 back-to-back while the RAM returns addr*3 -> `wb_rvalid` high for 3 consecutive cycles with `wb_rdata` 15, 18, 21; `host_rvalid` stays 0.
- **Contention, MAX_WB_BURST = 8:** both reqs held for 18 cycles -> grant pattern wb×8, host, wb×8, host; `run_cnt` returns to 0 after each host grant.
- **Level check, `obuff_w_level` = 100:** host reads addr 99, then addr 100 -> first response has `host_rerr` 0 and carries the RAM data; second has `host_rerr` 1, `host_rdata` 0, and `obuff_r_en` stays low in its grant cycle.
- **Pause mid-stream:** wb granted at T, `pause_work` = 1 for T+1..T+4 -> `wb_rvalid` at T+1, no grants during T+1..T+4, `run_cnt` and `owner` held, next grant at T+5.
- **Reset mid-flight:** host granted at T, `rst` = 0 at T+1 -> no `host_rvalid` at T+1 or at any cycle before a new grant.
